// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises bitstream words onto a configuration chain,
// then recirculates the chain once to verify the loaded ones-count.
`default_nettype none

module ccff_chain_loader #(
  parameter int WORD_WIDTH = 8,
  parameter int CHAIN_LEN  = 8,
  parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  ccff_head,
  output logic                  ccff_clk_en,
  input  logic                  ccff_tail,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int BL_W  = $clog2(WORD_WIDTH + 1);
  localparam int SUM_W = ((CNT_W > BL_W) ? CNT_W : BL_W) + 1;
  localparam logic [CNT_W-1:0] LEN      = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LEN_M1   = CNT_W'(CHAIN_LEN - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_LOAD     = 2'd1;
  localparam logic [1:0] S_READBACK = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      bits_sent_q, bits_sent_d;
  logic [CNT_W-1:0]      ones_loaded_q, ones_loaded_d;
  logic [CNT_W-1:0]      ones_read_q, ones_read_d;
  logic [CNT_W-1:0]      rb_cnt_q, rb_cnt_d;
  logic [WORD_WIDTH-1:0] buf_q, buf_d;
  logic [BL_W-1:0]       buf_left_q, buf_left_d;
  logic                  head_q, head_d;
  logic                  clk_en_q, clk_en_d;
  logic                  error_q, error_d;

  logic                  w_issue;
  logic                  w_need_more;
  logic                  w_accept;
  logic                  w_idle_start;
  logic [SUM_W-1:0]      w_sent_next;
  logic [SUM_W-1:0]      w_remaining;
  logic [BL_W-1:0]       w_load_len;
  logic [CNT_W-1:0]      w_ones_read_next;

  assign w_issue      = (state_q == S_LOAD) && (buf_left_q != '0);
  assign w_need_more  = (SUM_W'(bits_sent_q) + SUM_W'(buf_left_q)) < SUM_W'(CHAIN_LEN);
  assign w_accept     = word_valid && word_ready;
  assign w_idle_start = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  // A word is sized against what the chain still needs after this cycle's issue.
  assign w_sent_next  = SUM_W'(bits_sent_q) + SUM_W'(w_issue);
  assign w_remaining  = SUM_W'(CHAIN_LEN) - w_sent_next;
  assign w_load_len   = (w_remaining < SUM_W'(WORD_WIDTH)) ? BL_W'(w_remaining)
                                                           : BL_W'(WORD_WIDTH);
  assign w_ones_read_next = ones_read_q + CNT_W'(ccff_tail);

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q       <= S_IDLE;
      bits_sent_q   <= '0;
      ones_loaded_q <= '0;
      ones_read_q   <= '0;
      rb_cnt_q      <= '0;
      buf_q         <= '0;
      buf_left_q    <= '0;
      head_q        <= 1'b0;
      clk_en_q      <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      bits_sent_q   <= bits_sent_d;
      ones_loaded_q <= ones_loaded_d;
      ones_read_q   <= ones_read_d;
      rb_cnt_q      <= rb_cnt_d;
      buf_q         <= buf_d;
      buf_left_q    <= buf_left_d;
      head_q        <= head_d;
      clk_en_q      <= clk_en_d;
      error_q       <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_LOAD;
      S_LOAD:         if (bits_sent_q == LEN) state_d = S_READBACK;
      S_READBACK:     if (rb_cnt_q == LEN_M1) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bits_sent_d   = bits_sent_q;
    ones_loaded_d = ones_loaded_q;
    ones_read_d   = ones_read_q;
    rb_cnt_d      = rb_cnt_q;
    buf_d         = buf_q;
    buf_left_d    = buf_left_q;
    head_d        = head_q;
    clk_en_d      = 1'b0;
    error_d       = error_q;
    if (w_idle_start) begin
      bits_sent_d   = '0;
      ones_loaded_d = '0;
      ones_read_d   = '0;
      rb_cnt_d      = '0;
      buf_left_d    = '0;
      error_d       = 1'b0;
    end else if (state_q == S_LOAD) begin
      if (w_issue) begin
        head_d        = buf_q[WORD_WIDTH-1];
        clk_en_d      = 1'b1;
        buf_d         = buf_q << 1;
        buf_left_d    = buf_left_q - BL_W'(1);
        bits_sent_d   = bits_sent_q + CNT_W'(1);
        ones_loaded_d = ones_loaded_q + CNT_W'(buf_q[WORD_WIDTH-1]);
      end
      if (w_accept) begin
        buf_d      = word_in;
        buf_left_d = w_load_len;
      end
      // The last loaded bit is in flight; the first recirculation edge follows it.
      if (bits_sent_q == LEN) clk_en_d = 1'b1;
    end else if (state_q == S_READBACK) begin
      ones_read_d = w_ones_read_next;
      rb_cnt_d    = rb_cnt_q + CNT_W'(1);
      if (rb_cnt_q == LEN_M1) error_d = (w_ones_read_next != ones_loaded_q);
      else                    clk_en_d = 1'b1;
    end
  end

  always_comb begin
    word_ready  = (state_q == S_LOAD) && w_need_more &&
                  ((buf_left_q == '0) || (buf_left_q == BL_W'(1)));
    busy        = (state_q == S_LOAD) || (state_q == S_READBACK);
    done        = (state_q == S_DONE);
    ccff_head   = (state_q == S_READBACK) ? ccff_tail : head_q;
    ccff_clk_en = clk_en_q;
    error       = error_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
// Scoreboarded bench for ccff_chain_loader driving a modelled 10-FF chain.
`default_nettype none

module tb_ccff_chain_loader;

  localparam int W = 8;
  localparam int N = 10;

  logic         prog_clk = 1'b0;
  logic         prog_reset;
  logic         start;
  logic [W-1:0] word_in;
  logic         word_valid;
  logic         word_ready;
  logic         ccff_head;
  logic         ccff_clk_en;
  logic         ccff_tail;
  logic         busy;
  logic         done;
  logic         error;

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(.WORD_WIDTH(W), .CHAIN_LEN(N)) dut (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .start      (start),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .ccff_head  (ccff_head),
    .ccff_clk_en(ccff_clk_en),
    .ccff_tail  (ccff_tail),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  // Chain model: first bit shifted in ends up at the tail (MSB).
  logic [N-1:0] chain = '0;
  logic         fault = 1'b0;
  always @(posedge prog_clk) if (ccff_clk_en) chain <= {chain[N-2:0], ccff_head};
  assign ccff_tail = fault ? 1'b0 : chain[N-1];

  typedef struct {
    logic         err;
    logic [N-1:0] cfg;
  } res_t;

  int   vectors    = 0;
  int   miscompares = 0;
  bit   exp_bits[$];
  res_t exp_res[$];
  int   en_cnt = 0;
  int   rb_cnt = 0;
  logic done_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: consumes expected load bits on enabled cycles, results on done.
  always @(negedge prog_clk) begin
    bit   b;
    res_t r;
    if (!prog_reset && ccff_clk_en) begin
      if (en_cnt < N) begin
        if (exp_bits.size() == 0) check("unexpected_bit", 1, 0);
        else begin
          b = exp_bits.pop_front();
          check($sformatf("load_bit%0d", en_cnt), int'(ccff_head), int'(b));
        end
        en_cnt++;
      end else begin
        rb_cnt++;
      end
    end
    if (done && !done_prev) begin
      if (exp_res.size() == 0) check("unexpected_done", 1, 0);
      else begin
        r = exp_res.pop_front();
        check("error_flag", int'(error), int'(r.err));
        check("chain_cfg", int'(chain), int'(r.cfg));
        check("readback_cycles", rb_cnt, N);
        check("busy_at_done", int'(busy), 0);
      end
    end
    done_prev = done;
  end

  task automatic check_reset_outputs(input string name);
    check(name, int'({word_ready, ccff_head, ccff_clk_en, busy, done, error}), 0);
  endtask

  task automatic wait_ready();
    int t = 0;
    do begin
      @(negedge prog_clk);
      t++;
    end while (!word_ready && t < 50);
    if (!word_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic push_expect(input logic [W-1:0] w0, input logic [W-1:0] w1, input bit flt);
    bit   q[$];
    int   ones = 0;
    res_t r;
    for (int i = W - 1; i >= 0; i--) q.push_back(w0[i]);
    for (int i = W - 1; i >= 0; i--) q.push_back(w1[i]);
    while (q.size() > N) void'(q.pop_back());
    r.cfg = '0;
    foreach (q[i]) begin
      exp_bits.push_back(q[i]);
      ones += int'(q[i]);
      r.cfg = {r.cfg[N-2:0], q[i]};
    end
    // A stuck-at-0 tail recirculates zeros, so the chain ends cleared.
    r.err = flt ? (ones != 0) : 1'b0;
    if (flt) r.cfg = '0;
    exp_res.push_back(r);
  endtask

  task automatic pulse_start();
    en_cnt = 0;
    rb_cnt = 0;
    start = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0;
  endtask

  task automatic run_load(input logic [W-1:0] w0, input logic [W-1:0] w1,
                          input bit stall, input bit flt, input bit poke);
    int t = 0;
    push_expect(w0, w1, flt);
    fault = flt;
    pulse_start();
    check("start_clears_error", int'(error), 0);
    check("start_clears_done", int'(done), 0);
    check("busy_after_start", int'(busy), 1);
    word_in = w0; word_valid = 1'b1;
    wait_ready();
    @(posedge prog_clk); #1;
    word_valid = 1'b0;
    if (poke) begin
      repeat (2) begin @(posedge prog_clk); #1; end
      start = 1'b1;
      @(posedge prog_clk); #1;
      start = 1'b0;
    end
    if (stall) begin
      wait_ready();
      @(posedge prog_clk); #1;
      @(posedge prog_clk); #1;
      check("stall_clk_en_a", int'(ccff_clk_en), 0);
      @(posedge prog_clk); #1;
      check("stall_clk_en_b", int'(ccff_clk_en), 0);
    end
    word_in = w1; word_valid = 1'b1;
    wait_ready();
    @(posedge prog_clk); #1;
    word_valid = 1'b0;
    while (!done && t < 200) begin
      @(negedge prog_clk);
      t++;
    end
    if (!done) check("done_timeout", 0, 1);
    @(posedge prog_clk); #1;
    word_in = $urandom; word_valid = 1'b1;
    @(posedge prog_clk); #1;
    check("ready_outside_load", int'(word_ready), 0);
    word_valid = 1'b0;
    fault = 1'b0;
  endtask

  task automatic reset_mid_load();
    int t = 0;
    push_expect(8'hA5, 8'h00, 1'b0);
    pulse_start();
    word_in = 8'hA5; word_valid = 1'b1;
    wait_ready();
    @(posedge prog_clk); #1;
    word_valid = 1'b0;
    while (en_cnt < 4 && t < 50) begin
      @(negedge prog_clk);
      t++;
    end
    if (en_cnt < 4) check("midload_timeout", 0, 1);
    #2 prog_reset = 1'b1;
    #1 check_reset_outputs("async_reset_outputs");
    exp_bits.delete();
    exp_res.delete();
    en_cnt = 0;
    @(posedge prog_clk); #1;
    prog_reset = 1'b0;
  endtask

  initial begin
    prog_reset = 1'b1;
    start      = 1'b0;
    word_in    = '0;
    word_valid = 1'b0;
    #1 check_reset_outputs("reset_outputs");
    repeat (2) @(posedge prog_clk);
    #1 prog_reset = 1'b0;

    run_load(8'hA5, 8'hC0, 1'b0, 1'b0, 1'b0);
    run_load(8'hFF, 8'hC0, 1'b0, 1'b0, 1'b0);
    run_load(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0);
    run_load(8'hA5, 8'h00, 1'b0, 1'b1, 1'b0);
    run_load(8'h3C, 8'h40, 1'b0, 1'b0, 1'b1);
    reset_mid_load();
    run_load(8'h3C, 8'h80, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      run_load(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));

    check("leftover_bits", exp_bits.size(), 0);
    check("leftover_results", exp_res.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Writer side of the configuration-chain protocol used by the connection-block and switch-block memories. Those memories consume ccff_head, shift on prog_clk and return ccff_tail.
- The block accepts bitstream words over a valid/ready handshake and serialises exactly CHAIN_LEN bits onto ccff_head, qualified by ccff_clk_en for the external prog_clk gate.
- It then recirculates the chain once (tail fed back to head) to verify the loaded ones-count without disturbing the configuration.
- One instance drives one chain segment at tile or fabric level.

Parameters:
- WORD_WIDTH, 8, bits per input bitstream word.
- CHAIN_LEN, 8, total configuration flip-flops in the driven chain (>=1).
- CNT_W, $clog2(CHAIN_LEN+1), width of bit and ones counters.

Ports:
- prog_clk  input  1  programming clock; all state on the rising edge.
- prog_reset  input  1  asynchronous reset, active-high.
- start  input  1  single-cycle pulse that begins a load; ignored unless state is IDLE or DONE.
- word_in  input  WORD_WIDTH  bitstream word, shifted out MSB first.
- word_valid  input  1  word_in is valid.
- word_ready  output  1  loader accepts word_in this cycle (transfer = valid && ready).
- ccff_head  output  1  serial configuration data to the chain head.
- ccff_clk_en  output  1  registered enable; the chain shifts on a prog_clk edge only while this is 1.
- ccff_tail  input  1  serial data from the chain tail.
- busy  output  1  high in LOAD or READBACK.
- done  output  1  high in DONE.
- error  output  1  readback ones-count mismatch; sticky until next accepted start.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; all counters and the word buffer cleared.
  - All outputs 0: word_ready, ccff_head, ccff_clk_en, busy, done, error.
- States are IDLE, LOAD, READBACK, DONE.
- IDLE/DONE + start:
  - LOAD next cycle; bits_sent=0, ones_loaded=0, error=0, done=0.
- LOAD, word buffer:
  - Single-word buffer holding buf_bits_left.
  - word_ready=1 when the buffer is empty, or when the buffer's final needed bit is issued this cycle, so back-to-back words cause no bubble.
  - Each accepted word loads buf_bits_left = min(WORD_WIDTH, CHAIN_LEN - bits_sent - bits still in buffer).
  - Low-order bits beyond CHAIN_LEN in the final word are discarded.
- LOAD, shifting:
  - Each cycle with buffer non-empty: register ccff_head=next MSB-side bit and ccff_clk_en=1; increment bits_sent; increment ones_loaded if the bit is 1.
  - If the buffer is empty (starved): ccff_clk_en=0 and ccff_head holds its value; the chain does not shift.
  - The first bit issued ends at the chain's last flip-flop.
- LOAD -> READBACK:
  - Transition in the cycle after the enabled cycle carrying bit CHAIN_LEN.
  - word_ready=0 from that cycle until the next start.
- READBACK:
  - ccff_head is a combinational copy of ccff_tail, so the chain recirculates and the configuration is preserved.
  - ccff_clk_en=1 for exactly CHAIN_LEN consecutive cycles.
  - ccff_tail is sampled on each enabled edge into ones_read.
- READBACK -> DONE:
  - Entered after the CHAIN_LEN-th enabled cycle; ccff_clk_en=0 in DONE.
  - error=1 if ones_read != ones_loaded.
  - done=1 until the next start.
- busy = (state==LOAD || state==READBACK).
- start while busy: ignored, no side effects.
- word_valid outside LOAD: ignored; word_ready stays 0.
- Reset mid-operation: immediate return to IDLE with reset outputs. Chain contents are undefined and must be reloaded.
- Arithmetic: counters are unsigned CNT_W bits and never exceed CHAIN_LEN; no wrap.

Test Plan:
- Bench chain model: CHAIN_LEN-bit shift register that shifts only when ccff_clk_en=1.
- Nominal load (CHAIN_LEN=8, WORD_WIDTH=8): start, word 0xA5 -> ccff_head sequence 1,0,1,0,0,1,0,1 over 8 consecutive enabled cycles; model holds 0xA5; 8 readback cycles; done=1, error=0; model still 0xA5.
- Partial final word (CHAIN_LEN=10): words 0xFF and 0xC0 -> 10 enabled cycles with bits 1x8 then 1,1; second word's low 6 bits discarded; ones_loaded=10; done=1, error=0.
- Starvation: word_valid held low 3 cycles mid-stream between two words -> ccff_clk_en=0 for those cycles; model content identical to the unstalled run.
- Faulty chain: model tail forced to 0 during readback, load 0xA5 -> done=1, error=1; next start clears error.
- Start while busy: pulse start in LOAD cycle 3 -> no restart; bit sequence unchanged.
- Reset mid-load: assert prog_reset after 4 bits -> all outputs 0 asynchronously, state IDLE; a subsequent start plus 0x3C load completes with error=0.
